// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator ALU.
// Opcode and FSM state encodings used by the top and the bench.
package calc_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD,
    OP_SUB,
    OP_OR,
    OP_NEQ,
    OP_AND,
    OP_XOR,
    OP_MUL,
    OP_CLRACC
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } state_t;

endpackage

// File: rtl/calc_shift_add_mul.sv
// Fixed-latency shift-add multiplier, one step per cycle.
// Ports: clock, clear, start, a, b -> done (final step), product.
module calc_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  assign prod_nxt = mplier[0] ? prod + mcand : prod;

  // product is the value being written on the final step, so the
  // consumer can register it on the same edge done is seen
  assign done    = run && (cnt == CW'(WIDTH - 1));
  assign product = prod_nxt;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      prod   <= '0;
      mplier <= b;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/register.sv
// Enabled D register with async active-high clear.
// Ports: clock, clear, en, d[W] -> q[W].
module register #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge clear) begin
    if (clear)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/calc_seq_alu.sv
// Sequential calculator: valid/ready ALU with accumulator and shift-add MUL.
// Ports: clock, clear, in_valid/in_ready, a, b, op, use_acc,
//        out_valid/out_ready, result, carry, overflow, zero, acc, busy.
module calc_seq_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  state_t state;
  state_t state_nxt;
  op_t    opc;

  logic               accept;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic               wr_en;
  logic [WIDTH-1:0]   res_d;
  logic [2:0]         flg_d;
  logic [2:0]         flg_q;

  assign opc    = op_t'(op);
  assign accept = in_valid && in_ready;
  assign opa    = use_acc ? acc : a;

  always_comb begin
    sum     = {1'b0, opa} + {1'b0, b};
    diff    = {1'b0, opa} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opc)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (opa[WIDTH-1] == b[WIDTH-1]) &&
                  (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        // borrow out of the widened difference is exactly A<B
        alu_c   = diff[WIDTH];
        alu_v   = (opa[WIDTH-1] != b[WIDTH-1]) &&
                  (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_OR:  alu_res = opa | b;
      OP_NEQ: alu_res = {{(WIDTH-1){1'b0}}, opa != b};
      OP_AND: alu_res = opa & b;
      OP_XOR: alu_res = opa ^ b;
      default: ;
    endcase
  end

  assign mul_start = accept && (opc == OP_MUL);

  calc_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .clear   (clear),
    .start   (mul_start),
    .a       (opa),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  assign wr_en = (accept && (opc != OP_MUL)) ||
                 ((state == S_MUL) && mul_done);

  always_comb begin
    if (state == S_MUL) begin
      res_d    = product[WIDTH-1:0];
      flg_d[2] = |product[2*WIDTH-1:WIDTH];
      flg_d[1] = 1'b0;
    end else begin
      res_d    = alu_res;
      flg_d[2] = alu_c;
      flg_d[1] = alu_v;
    end
    flg_d[0] = (res_d == '0);
  end

  register #(.W(WIDTH)) u_result (
    .clock (clock), .clear (clear), .en (wr_en),
    .d (res_d), .q (result)
  );

  register #(.W(3)) u_flags (
    .clock (clock), .clear (clear), .en (wr_en),
    .d (flg_d), .q (flg_q)
  );

  // every registered result, including CLRACC's zero, lands in acc
  register #(.W(WIDTH)) u_acc (
    .clock (clock), .clear (clear), .en (wr_en),
    .d (res_d), .q (acc)
  );

  assign carry    = flg_q[2];
  assign overflow = flg_q[1];
  assign zero     = flg_q[0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (accept)
          state_nxt = (opc == OP_MUL) ? S_MUL : S_HOLD;
      end
      (state == S_MUL): begin
        if (mul_done) state_nxt = S_HOLD;
      end
      (state == S_HOLD): begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_HOLD);
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_calc_seq_alu.sv
// Self-checking bench for calc_seq_alu (WIDTH=8).
// Directed scenarios plus randomized ops against an arithmetic model.
module tb_calc_seq_alu;

  localparam int W = 8;

  logic         clock;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         use_acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic [W-1:0] acc;
  logic         busy;

  int checks;
  int errors;
  int acc_m;

  calc_seq_alu #(.WIDTH(W), .OP_W(3)) dut (
    .clock     (clock),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .acc       (acc),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // returns {result[7:0], carry, overflow, zero}
  function automatic logic [10:0] model(input int ai, input int bi,
                                        input int opi);
    int r, sa, sb, s;
    logic c, o;
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    c = 1'b0;
    o = 1'b0;
    case (opi)
      0: begin
        r = ai + bi; c = (r > 255);
        s = sa + sb; o = (s > 127) || (s < -128);
      end
      1: begin
        r = ai - bi; c = (ai < bi);
        s = sa - sb; o = (s > 127) || (s < -128);
      end
      2: r = ai | bi;
      3: r = (ai != bi) ? 1 : 0;
      4: r = ai & bi;
      5: r = ai ^ bi;
      6: begin r = ai * bi; c = (r > 255); end
      default: r = 0;
    endcase
    r = r & 255;
    return {r[7:0], c, o, (r == 0)};
  endfunction

  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                        input logic [2:0] opi, input logic ua,
                        output logic [7:0] r, output logic c,
                        output logic o, output logic z,
                        output logic [7:0] ac, output int lat,
                        output logic ir_seen);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin step(); n++; end
    a = ai; b = bi; op = opi; use_acc = ua; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    op = 3'($urandom); use_acc = 1'($urandom);
    lat = 1;
    ir_seen = 1'b0;
    while (!out_valid && lat < 30) begin
      if (in_ready) ir_seen = 1'b1;
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
    r = result; c = carry; o = overflow; z = zero; ac = acc;
    step();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_hs got %b want 100", {in_ready, out_valid, busy});
    end
    checks++;
    if ({result, carry, overflow, zero, acc} !== '0) begin
      errors++;
      $display("FAIL reset_data res=%0d c=%b v=%b z=%b acc=%0d want 0",
               result, carry, overflow, zero, acc);
    end
    step();
    clear = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    acc_m = 0;
  endtask

  task automatic test_add();
    logic [7:0] r, ac; logic c, o, z, irs; int lat;
    run_op(8'd200, 8'd100, 3'd0, 1'b0, r, c, o, z, ac, lat, irs);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL add_lat got %0d want 1", lat); end
    checks++;
    if ({r, c, o, z} !== {8'd44, 3'b100}) begin
      errors++;
      $display("FAIL add got r=%0d c=%b v=%b z=%b want 44 1 0 0", r, c, o, z);
    end
    checks++;
    if (ac !== 8'd44) begin errors++; $display("FAIL add_acc got %0d want 44", ac); end
    acc_m = 44;
  endtask

  task automatic test_sub_neq();
    logic [7:0] r, ac; logic c, o, z, irs; int lat;
    run_op(8'h80, 8'h01, 3'd1, 1'b0, r, c, o, z, ac, lat, irs);
    checks++;
    if ({r, c, o, z} !== {8'h7F, 3'b010}) begin
      errors++;
      $display("FAIL sub got r=%0h c=%b v=%b z=%b want 7f 0 1 0", r, c, o, z);
    end
    run_op(8'd5, 8'd5, 3'd3, 1'b0, r, c, o, z, ac, lat, irs);
    checks++;
    if ({r, c, o, z} !== {8'd0, 3'b001}) begin
      errors++;
      $display("FAIL neq got r=%0d c=%b v=%b z=%b want 0 0 0 1", r, c, o, z);
    end
    checks++;
    if (ac !== 8'd0) begin errors++; $display("FAIL neq_acc got %0d want 0", ac); end
    acc_m = 0;
  endtask

  task automatic test_mul();
    logic [7:0] r, ac; logic c, o, z, irs; int lat;
    run_op(8'd20, 8'd13, 3'd6, 1'b0, r, c, o, z, ac, lat, irs);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL mul_lat got %0d want 9", lat); end
    checks++;
    if ({r, c, o, z} !== {8'd4, 3'b100}) begin
      errors++;
      $display("FAIL mul got r=%0d c=%b v=%b z=%b want 4 1 0 0", r, c, o, z);
    end
    checks++;
    if (irs !== 1'b0) begin errors++; $display("FAIL mul_in_ready got 1 want 0"); end
    run_op(8'd0, 8'd77, 3'd6, 1'b0, r, c, o, z, ac, lat, irs);
    checks++;
    if (lat !== 9 || r !== 8'd0 || z !== 1'b1) begin
      errors++;
      $display("FAIL mul_zero lat=%0d r=%0d z=%b want 9 0 1", lat, r, z);
    end
    acc_m = 0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    a = 8'd3; b = 8'd4; op = 3'd0; use_acc = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 8'd7) begin
        errors++;
        $display("FAIL hold_%0d ov=%b r=%0d want 1 7", i, out_valid, result);
      end
      if (i == 2) begin
        a = 8'd9; b = 8'd9; op = 3'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || acc !== 8'd7) begin
      errors++;
      $display("FAIL not_queued ov=%b acc=%0d want 0 7", out_valid, acc);
    end
    acc_m = 7;
  endtask

  task automatic test_accumulate();
    logic [7:0] r, ac; logic c, o, z, irs; int lat;
    run_op(8'd55, 8'd66, 3'd7, 1'b0, r, c, o, z, ac, lat, irs);
    checks++;
    if (r !== 8'd0 || z !== 1'b1 || ac !== 8'd0) begin
      errors++;
      $display("FAIL clracc r=%0d z=%b acc=%0d want 0 1 0", r, z, ac);
    end
    for (int k = 1; k <= 3; k++) begin
      run_op(8'($urandom), 8'd10, 3'd0, 1'b1, r, c, o, z, ac, lat, irs);
      checks++;
      if (ac !== 8'(10 * k) || r !== 8'(10 * k)) begin
        errors++;
        $display("FAIL accum_%0d acc=%0d r=%0d want %0d", k, ac, r, 10 * k);
      end
    end
    acc_m = 30;
  endtask

  task automatic test_clear_mid_mul();
    logic [7:0] r, ac; logic c, o, z, irs; int lat; logic seen;
    a = 8'd20; b = 8'd13; op = 3'd6; use_acc = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    clear = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, result, carry, overflow, zero, acc} !== '0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_clear ov=%b busy=%b r=%0d acc=%0d ir=%b",
               out_valid, busy, result, acc, in_ready);
    end
    step();
    clear = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL aborted_mul out_valid rose"); end
    acc_m = 0;
    run_op(8'd1, 8'd2, 3'd0, 1'b0, r, c, o, z, ac, lat, irs);
    checks++;
    if (lat !== 1 || r !== 8'd3 || ac !== 8'd3) begin
      errors++;
      $display("FAIL after_clear lat=%0d r=%0d acc=%0d want 1 3 3", lat, r, ac);
    end
    acc_m = 3;
  endtask

  task automatic test_random();
    logic [7:0] r, ac, ai, bi; logic c, o, z, irs, ua; int lat;
    logic [2:0] opi; logic [10:0] exp; int ea;
    for (int i = 0; i < 60; i++) begin
      ai = 8'($urandom); bi = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bi = ai;
      opi = 3'($urandom_range(0, 7));
      ua = 1'($urandom);
      ea = ua ? acc_m : int'(ai);
      exp = model(ea, int'(bi), int'(opi));
      run_op(ai, bi, opi, ua, r, c, o, z, ac, lat, irs);
      checks++;
      if ({r, c, o, z} !== exp || ac !== exp[10:3] ||
          lat !== ((opi == 3'd6) ? 9 : 1)) begin
        errors++;
        $display("FAIL rand_%0d op=%0d a=%0d b=%0d got r=%0d cvz=%b%b%b acc=%0d lat=%0d want r=%0d cvz=%b lat=%0d",
                 i, opi, ea, bi, r, c, o, z, ac, lat, exp[10:3], exp[2:0],
                 (opi == 3'd6) ? 9 : 1);
      end
      acc_m = int'(exp[10:3]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    acc_m = 0;
    clear = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    use_acc = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub_neq();
    test_mul();
    test_backpressure();
    test_accumulate();
    test_clear_mid_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
